// File: rtl/nios_system_cpu_oci_trace_pkg.sv
// Shared definitions for the OCI trace monitor: FSM encoding and drop-counter sizing.
package nios_system_cpu_oci_trace_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_DONE  = 2'd2
  } trace_state_e;

  localparam int DROP_W = 16;
  localparam logic [DROP_W-1:0] DROP_MAX = 16'hFFFF;

endpackage

// File: rtl/nios_system_cpu_oci_trace_fifo.sv
// Circular trace FIFO: up to SLOTS writes per cycle, one read per cycle, registered level.
module nios_system_cpu_oci_trace_fifo
  import nios_system_cpu_oci_trace_pkg::*;
#(
  parameter int SLOT_W = 10,
  parameter int SLOTS  = 3,
  parameter int DEPTH  = 16,
  parameter int LVL_W  = $clog2(DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [SLOT_W*SLOTS-1:0]   wr_data,
  input  logic [LVL_W-1:0]          wr_num,
  input  logic                      rd_ready,
  output logic [SLOT_W-1:0]         rd_data,
  output logic                      rd_valid,
  output logic [LVL_W-1:0]          level,
  output logic [LVL_W-1:0]          level_next
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [SLOT_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              pop;

  assign rd_valid   = (level != '0);
  assign rd_data    = mem[rd_ptr];
  assign pop        = rd_valid & rd_ready;
  assign level_next = level + wr_num - LVL_W'(pop);

  // Storage is data only and deliberately left out of reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < SLOTS; i++) begin
      if (LVL_W'(i) < wr_num)
        mem[wr_ptr + PTR_W'(i)] <= wr_data[i*SLOT_W +: SLOT_W];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      wr_ptr <= wr_ptr + PTR_W'(wr_num);
      if (pop)
        rd_ptr <= rd_ptr + PTR_W'(1);
      level  <= level_next;
    end
  end

endmodule

// File: rtl/nios_system_cpu_oci_trace_monitor.sv
// OCI trace monitor top: count clamping, free-space arbitration, run/flush/done FSM, statistics.
module nios_system_cpu_oci_trace_monitor
  import nios_system_cpu_oci_trace_pkg::*;
#(
  parameter int SLOT_W = 10,
  parameter int SLOTS  = 3,
  parameter int CNT_W  = 4,
  parameter int DEPTH  = 16,
  parameter int LVL_W  = $clog2(DEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [SLOT_W*SLOTS-1:0]  dct_buffer,
  input  logic [CNT_W-1:0]         dct_count,
  input  logic                     test_ending,
  input  logic                     test_has_ended,
  output logic [SLOT_W-1:0]        rd_data,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [LVL_W-1:0]         level,
  output logic                     overflow,
  output logic                     count_err,
  output logic [15:0]              drop_count,
  output logic [1:0]               state,
  output logic                     flush_done
);

  localparam int CW  = (CNT_W > LVL_W) ? CNT_W : LVL_W;
  localparam int DSW = DROP_W + 1;

  trace_state_e      state_q, state_d;
  logic              flush_d;
  logic [CW-1:0]     cnt_ext;
  logic [CW-1:0]     n_eff;
  logic [LVL_W-1:0]  n_lvl;
  logic [LVL_W-1:0]  free_slots;
  logic [LVL_W-1:0]  wr_num;
  logic [LVL_W-1:0]  dropped;
  logic [LVL_W-1:0]  level_next;
  logic [DSW-1:0]    drop_sum;
  logic              cnt_over;

  assign cnt_ext    = CW'(dct_count);
  assign cnt_over   = (cnt_ext > CW'(SLOTS));
  assign n_eff      = cnt_over ? CW'(SLOTS) : cnt_ext;
  assign n_lvl      = LVL_W'(n_eff);
  // Free space uses the pre-pop level, so a same-cycle pop never makes room for a write.
  assign free_slots = LVL_W'(DEPTH) - level;
  assign wr_num     = (state_q != ST_RUN) ? '0 :
                      (n_lvl < free_slots) ? n_lvl : free_slots;
  assign dropped    = (state_q == ST_RUN) ? (n_lvl - wr_num) : '0;
  assign drop_sum   = {1'b0, drop_count} + DSW'(dropped);
  assign state      = state_q;

  nios_system_cpu_oci_trace_fifo #(
    .SLOT_W (SLOT_W),
    .SLOTS  (SLOTS),
    .DEPTH  (DEPTH),
    .LVL_W  (LVL_W)
  ) u_fifo (
    .clk        (clk),
    .reset_n    (reset_n),
    .wr_data    (dct_buffer),
    .wr_num     (wr_num),
    .rd_ready   (rd_ready),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .level      (level),
    .level_next (level_next)
  );

  always_comb begin
    state_d = state_q;
    flush_d = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (test_has_ended)
          state_d = ST_DONE;
        else if (test_ending)
          state_d = ST_FLUSH;
      end
      ST_FLUSH: begin
        if (test_has_ended) begin
          state_d = ST_DONE;
        end else if (level_next == '0) begin
          state_d = ST_DONE;
          flush_d = 1'b1;
        end
      end
      default: state_d = ST_DONE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= ST_RUN;
      flush_done <= 1'b0;
      overflow   <= 1'b0;
      count_err  <= 1'b0;
      drop_count <= '0;
    end else begin
      state_q    <= state_d;
      flush_done <= flush_d;
      if (dropped != '0)
        overflow <= 1'b1;
      if (cnt_over)
        count_err <= 1'b1;
      drop_count <= drop_sum[DROP_W] ? DROP_MAX : drop_sum[DROP_W-1:0];
    end
  end

endmodule

// File: doc/nios_system_cpu_oci_trace_monitor.md
# nios_system_cpu_oci_trace_monitor

Parametrised trace-capture buffer for the Nios II on-chip-instrumentation (OCI) debug path. Each cycle it packs up to SLOTS trace slots from the packed `dct_buffer` bus, as qualified by `dct_count`, into a circular FIFO. Software-visible logic or the bench drains the FIFO one slot per cycle over a valid/ready port. `test_ending` starts a controlled drain, `test_has_ended` freezes capture, and overflow and dropped-slot statistics are kept.

## Interface
- SLOT_W, 10: bits per trace slot.
- SLOTS, 3: slots carried per cycle on `dct_buffer`.
- CNT_W, 4: width of `dct_count`.
- DEPTH, 16: FIFO entries, power of two, ≥ 2·SLOTS.
- LVL_W, $clog2(DEPTH+1): width of `level`.
- clk  in  1  single clock, all logic on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- dct_buffer  in  SLOT_W·SLOTS  packed slots, slot i at bits [i·SLOT_W +: SLOT_W].
- dct_count  in  CNT_W  number of valid slots this cycle, lowest first; 0 = nothing.
- test_ending  in  1  request drain-then-stop.
- test_has_ended  in  1  immediate stop.
- rd_data  out  SLOT_W  slot at FIFO head.
- rd_valid  out  1  FIFO not empty.
- rd_ready  in  1  consumer accepts `rd_data`.
- level  out  LVL_W  occupied entries.
- overflow  out  1  sticky, a slot was dropped for lack of space.
- count_err  out  1  sticky, `dct_count` > SLOTS was seen.
- drop_count  out  16  saturating count of dropped slots.
- state  out  2  RUN=0, FLUSH=1, DONE=2.
- flush_done  out  1  one-cycle pulse on FLUSH→DONE.

## Operation
- Effective count n = min(dct_count, SLOTS). If dct_count > SLOTS, set `count_err`.
- Writes are accepted only in RUN. Free space is DEPTH − level, sampled before this cycle's pop. The first min(n, free) slots are written in order (slot 0 first) at consecutive write-pointer positions.
- The remaining n − written slots are dropped. They are added to `drop_count`, saturating at 0xFFFF, and set `overflow` when nonzero.
- Pop occurs when rd_valid && rd_ready. A pop and a push in the same cycle are both performed: level_next = level + written − popped.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. `level` is a registered counter, and full/empty are derived from it.
- FSM:
  - RUN goes to DONE if `test_has_ended`, otherwise to FLUSH if `test_ending`. `test_has_ended` wins when both are asserted.
  - FLUSH ignores writes; these are not counted as drops. Pops continue. FLUSH goes to DONE when level_next == 0 or `test_has_ended`. `flush_done` pulses only on the level-based exit.
  - DONE ignores writes, pops continue, and the block stays in DONE until reset.
- Reset (any state, mid-transfer included): pointers = 0, level = 0, state = RUN, and `overflow`, `count_err`, `drop_count` and `flush_done` = 0. FIFO storage is not cleared.

## Timing
- All outputs are registered or decoded from registers only. Apart from `rd_data`/`rd_valid`, there is no combinational path from inputs to outputs.
- Write-to-read latency is 1 cycle: a slot captured at edge N gives `rd_valid` = 1 after edge N with that slot at the head.
- `level`, `overflow`, `drop_count` and `state` reflect edge-N events immediately after edge N.
- `flush_done` is high for exactly the cycle after the transition edge.

## Structure
- Package `nios_system_cpu_oci_trace_pkg` holds the state encoding constants (RUN/FLUSH/DONE) and the drop-counter width and saturation value.
- Sub-module `nios_system_cpu_oci_trace_fifo` is a DEPTH×SLOT_W storage array with multi-write (up to SLOTS per cycle) and single-read ports. It holds the pointers and level.
- The top level contains the FSM, count clamping, free-space arbitration and statistics.

## Test plan
- Reset, then dct_count=3 with slots 0x001/0x002/0x003 for one cycle, rd_ready=1. Required: rd_data returns 0x001, 0x002, 0x003 on consecutive cycles; level goes 3→2→1→0.
- Fill to level 15 with rd_ready=0, then write dct_count=3. Required: one slot stored, level=16, drop_count=2, overflow=1.
- Level=16, dct_count=2 with rd_ready=1 in the same cycle. Required: both slots dropped (free space is sampled before the pop), level=15, drop_count +2.
- dct_count=7. Required: 3 slots written, count_err=1.
- Level=4, test_ending pulse, rd_ready=1. Required: state=FLUSH, concurrent writes ignored, state=DONE after 4 pops, flush_done pulses for one cycle.
- Level=4, test_ending and test_has_ended together. Required: state=DONE, no flush_done. reset_n low for one cycle mid-flow then clears all outputs to their reset values.
